// File: rtl/tpm_spi_pkg.sv
// tpm_spi_pkg: shared constants, header field positions and FSM state type
// for the TPM SPI responder.
package tpm_spi_pkg;

    // Header byte 0 layout.
    localparam int HDR_RW_BIT  = 7;
    localparam int HDR_LEN_MSB = 6;
    localparam int HDR_BYTES   = 4;

    // Default register addresses.
    localparam logic [23:0] DEF_FIFO_ADDR = 24'hD40024;
    localparam logic [23:0] DEF_STS_ADDR  = 24'hD40018;

    // TPM_STS bit positions.
    localparam int STS_VALID_BIT      = 7;
    localparam int STS_CMD_READY_BIT  = 6;
    localparam int STS_DATA_AVAIL_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } tpm_state_e;

    // Status byte as seen by the host: valid, cmdReady when nothing is queued,
    // dataAvail when a response is waiting.
    function automatic logic [7:0] sts_byte(input logic empty);
        logic [7:0] v;
        v                     = 8'h00;
        v[STS_VALID_BIT]      = 1'b1;
        v[STS_CMD_READY_BIT]  = empty;
        v[STS_DATA_AVAIL_BIT] = ~empty;
        return v;
    endfunction

endpackage

// File: rtl/tpm_resp_fifo.sv
// tpm_resp_fifo: circular byte buffer holding the response stream served to
// FIFO reads. Pushes into a full buffer are dropped; pops of an empty one are
// ignored.
module tpm_resp_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [7:0]               i_wdata,
    input  logic                     i_rd,
    output logic [7:0]               o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_wr && !o_full;
    assign w_pop   = i_rd && !o_empty;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/tpm_spi_responder.sv
// tpm_spi_responder: TPM-side SPI FIFO protocol responder running entirely in
// the sys_clk domain. Optional build macro TPM_STS_REG_EN adds a TPM_STS read
// path at STS_ADDR; without it STS_ADDR reads like any other register (0xFF).
//
// state | meaning
// IDLE  | SS inactive, counters cleared
// HDR   | shifting in the 4-byte header, MISO held at 0
// DATA  | transferring len data bytes
// DONE  | all bytes moved, MISO at 1, clocks ignored until SS deasserts
module tpm_spi_responder
    import tpm_spi_pkg::*;
#(
    parameter logic [23:0] FIFO_ADDR     = DEF_FIFO_ADDR,
    parameter logic [23:0] STS_ADDR      = DEF_STS_ADDR,
    parameter int          RESP_DEPTH    = 32,
    parameter bit          SS_ACTIVE_LOW = 1'b1
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          ss_in,
    input  logic                          sclk_in,
    input  logic                          mosi_in,
    output logic                          miso_out,
    output logic [7:0]                    cmd_data,
    output logic                          cmd_valid,
    output logic                          cmd_frame_end,
    input  logic [7:0]                    resp_data,
    input  logic                          resp_wr,
    output logic                          resp_full,
    output logic [$clog2(RESP_DEPTH):0]   resp_level,
    output logic                          xfer_active,
    output logic                          err_underflow
);
`ifdef TPM_STS_REG_EN
    localparam bit STS_EN = 1'b1;
`else
    localparam bit STS_EN = 1'b0;
`endif
    localparam logic SS_IDLE = SS_ACTIVE_LOW;

    logic [1:0]  r_ss_s;
    logic [2:0]  r_sclk_s;
    logic [2:0]  r_mosi_s;
    logic        r_rise;
    logic        r_fall;
    tpm_state_e  r_state;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_cnt;
    logic [6:0]  r_shift_in;
    logic [7:0]  r_tx_sh;
    logic [15:0] r_addr_hi;
    logic [6:0]  r_len_m1;
    logic [7:0]  r_remain;
    logic        r_is_read;
    logic        r_is_fifo;
    logic        r_is_sts;
    logic        r_wr_frame;
    logic        r_miso;
    logic [7:0]  r_cmd_data;
    logic        r_cmd_valid;
    logic        r_frame_end;
    logic        r_err;

    logic        w_ss_act;
    logic [7:0]  w_byte;
    logic [23:0] w_addr;
    logic        w_load;
    logic        w_pop;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [7:0]  w_tx_byte;

    // Two-flop synchronizers plus registered sclk edge pulses; MOSI gets one
    // extra stage so it lines up with the edge pulse.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ss_s   <= {2{SS_IDLE}};
            r_sclk_s <= 3'b000;
            r_mosi_s <= 3'b000;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_ss_s   <= {r_ss_s[0], ss_in};
            r_sclk_s <= {r_sclk_s[1:0], sclk_in};
            r_mosi_s <= {r_mosi_s[1:0], mosi_in};
            r_rise   <= r_sclk_s[1] & ~r_sclk_s[2];
            r_fall   <= ~r_sclk_s[1] & r_sclk_s[2];
        end
    end

    assign w_ss_act = SS_ACTIVE_LOW ? ~r_ss_s[1] : r_ss_s[1];
    assign w_byte   = {r_shift_in, r_mosi_s[2]};
    assign w_addr   = {r_addr_hi, w_byte};

    // A new transmit byte is needed on the falling edge at every byte boundary
    // of a read while bytes remain.
    assign w_load = w_ss_act && (r_state == DATA) && r_fall && r_is_read &&
                    (r_bit_cnt == 3'd0) && (r_remain != 8'd0);
    assign w_pop  = w_load && r_is_fifo && !w_empty;

    // Select the byte a read returns from the decoded target register.
    always_comb begin
        w_tx_byte = 8'hFF;
        if (r_is_fifo) begin
            w_tx_byte = w_empty ? 8'hFF : w_head;
        end else if (STS_EN && r_is_sts) begin
            w_tx_byte = sts_byte(w_empty);
        end
    end

    // Protocol FSM: header decode, write delivery and read shifting.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_shift_in  <= 7'd0;
            r_tx_sh     <= 8'd0;
            r_addr_hi   <= 16'd0;
            r_len_m1    <= 7'd0;
            r_remain    <= 8'd0;
            r_is_read   <= 1'b0;
            r_is_fifo   <= 1'b0;
            r_is_sts    <= 1'b0;
            r_wr_frame  <= 1'b0;
            r_miso      <= 1'b0;
            r_cmd_data  <= 8'd0;
            r_cmd_valid <= 1'b0;
            r_frame_end <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_end <= 1'b0;
            if (!w_ss_act) begin
                r_state    <= IDLE;
                r_miso     <= 1'b0;
                r_wr_frame <= 1'b0;
                if (r_wr_frame) r_frame_end <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= HDR;
                        r_bit_cnt  <= 3'd0;
                        r_byte_cnt <= 2'd0;
                        r_shift_in <= 7'd0;
                        r_tx_sh    <= 8'd0;
                        r_miso     <= 1'b0;
                        r_is_fifo  <= 1'b0;
                        r_is_sts   <= 1'b0;
                    end
                    HDR: begin
                        if (r_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                if (r_byte_cnt == 2'd0) begin
                                    r_is_read <= w_byte[HDR_RW_BIT];
                                    r_len_m1  <= w_byte[HDR_LEN_MSB:0];
                                end else if (r_byte_cnt == 2'(HDR_BYTES - 1)) begin
                                    r_state    <= DATA;
                                    r_remain   <= {1'b0, r_len_m1} + 8'd1;
                                    r_is_fifo  <= (w_addr == FIFO_ADDR);
                                    r_is_sts   <= (w_addr == STS_ADDR);
                                    r_wr_frame <= !r_is_read && (w_addr == FIFO_ADDR);
                                end else begin
                                    r_addr_hi <= {r_addr_hi[7:0], w_byte};
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (r_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (!r_is_read && r_is_fifo) begin
                                    r_cmd_data  <= w_byte;
                                    r_cmd_valid <= 1'b1;
                                end
                                r_remain <= r_remain - 8'd1;
                                if (r_remain == 8'd1) begin
                                    r_state <= DONE;
                                    r_miso  <= 1'b1;
                                end
                            end
                        end else if (r_fall) begin
                            if (w_load) begin
                                r_tx_sh <= w_tx_byte;
                                r_miso  <= w_tx_byte[7];
                                if (r_is_fifo && w_empty) r_err <= 1'b1;
                            end else begin
                                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                                r_miso  <= r_tx_sh[6];
                            end
                        end
                    end
                    DONE: begin
                        r_miso <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    tpm_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .i_wr    (resp_wr),
        .i_wdata (resp_data),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_level (resp_level),
        .o_full  (resp_full),
        .o_empty (w_empty)
    );

    assign miso_out      = r_miso;
    assign cmd_data      = r_cmd_data;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_frame_end = r_frame_end;
    assign xfer_active   = w_ss_act;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_tpm_spi_responder.sv
// tb_tpm_spi_responder: directed vectors for the TPM SPI responder.
module tb_tpm_spi_responder;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_in = 1'b1;
    logic        sclk_in = 1'b0;
    logic        mosi_in = 1'b0;
    logic        miso_out;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_frame_end;
    logic [7:0]  resp_data = 8'h00;
    logic        resp_wr = 1'b0;
    logic        resp_full;
    logic [5:0]  resp_level;
    logic        xfer_active;
    logic        err_underflow;

    tpm_spi_responder dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .ss_in         (ss_in),
        .sclk_in       (sclk_in),
        .mosi_in       (mosi_in),
        .miso_out      (miso_out),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_frame_end (cmd_frame_end),
        .resp_data     (resp_data),
        .resp_wr       (resp_wr),
        .resp_full     (resp_full),
        .resp_level    (resp_level),
        .xfer_active   (xfer_active),
        .err_underflow (err_underflow)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef TPM_STS_REG_EN
    localparam logic [7:0] EXP_STS_EMPTY = 8'hC0;
    localparam logic [7:0] EXP_STS_AVAIL = 8'h90;
`else
    localparam logic [7:0] EXP_STS_EMPTY = 8'hFF;
    localparam logic [7:0] EXP_STS_AVAIL = 8'hFF;
`endif

    typedef struct {
        logic [31:0] hdr;
        int          n;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        bit          chk_rx;
        int          exp_cmd;
        int          exp_fe;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_cmd = 0;
    int         n_fe = 0;
    logic [7:0] cmd_q[$];
    logic [7:0] mq[$];
    time        t_last_rise = 0;
    time        t_ss_off = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse observer: sees cmd_valid/cmd_frame_end and their latencies
    // relative to the last sclk rise / SS deassert (rise at posedge+2, so the
    // 4th following posedge is observed at the negedge 43 time units later).
    always @(negedge sys_clk) begin
        if (!rst && cmd_valid) begin
            cmd_q.push_back(cmd_data);
            n_cmd++;
            check("cmd_valid_latency", 32'($time - t_last_rise), 32'd43);
        end
        if (!rst && cmd_frame_end) begin
            n_fe++;
            check("frame_end_latency", 32'($time - t_ss_off), 32'd33);
        end
    end

    task automatic spi_byte(input logic [7:0] v, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi_in = v[i];
            #80;
            r[i] = miso_out;
            sclk_in = 1'b1;
            t_last_rise = $time;
            #80;
            sclk_in = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] hdr, input int n, input logic [31:0] tx,
                             output logic [31:0] rx_hdr, output logic [31:0] rx);
        logic [7:0] b;
        rx_hdr = 32'h0;
        rx     = 32'h0;
        @(posedge sys_clk);
        #2;
        ss_in = 1'b0;
        #80;
        for (int k = 0; k < 4; k++) begin
            spi_byte(hdr[31-8*k -: 8], 8, b);
            rx_hdr[31-8*k -: 8] = b;
        end
        for (int k = 0; k < n; k++) begin
            spi_byte(tx[31-8*k -: 8], 8, b);
            rx[31-8*k -: 8] = b;
        end
        #80;
        ss_in = 1'b1;
        t_ss_off = $time;
        #400;
    endtask

    task automatic push(input logic [7:0] d);
        @(posedge sys_clk);
        #2;
        resp_data = d;
        resp_wr   = 1'b1;
        @(posedge sys_clk);
        #2;
        resp_wr   = 1'b0;
    endtask

    task automatic read4_model(input string name);
        logic [31:0] rxh, rx, exp;
        exp = 32'h0;
        for (int k = 0; k < 4; k++) exp[31-8*k -: 8] = (mq.size() > 0) ? mq.pop_front() : 8'hFF;
        spi_frame(32'h83D40024, 4, 32'h0, rxh, rx);
        check(name, rx, exp);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[20];
        logic [7:0]  wr_b[12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
                                  8'h00, 8'h00, 8'h01, 8'h7B, 8'h00, 8'h08};
        logic [31:0] rd_w[5]  = '{32'h80010000, 32'h00140000, 32'h00000008,
                                  32'h4A3B1C21, 32'h01A7CC09};
        logic [31:0] rxh, rx, cb;
        logic [7:0]  b, v;
        int          c0, f0;

        for (int i = 0; i < 12; i++)
            vt[i] = '{32'h00D40024, 1, {wr_b[i], 24'h0}, 32'h0, 1'b0, 1, 1};
        for (int i = 0; i < 5; i++)
            vt[12+i] = '{32'h83D40024, 4, 32'h0, rd_w[i], 1'b1, 0, 0};
        vt[17] = '{32'h80D40024, 1, 32'h0, 32'hFF000000, 1'b1, 0, 0};
        vt[18] = '{32'h03D40000, 4, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0};
        vt[19] = '{32'h83D40000, 4, 32'h0, 32'hFFFFFFFF, 1'b1, 0, 0};

        // Outputs while reset is held.
        repeat (4) @(posedge sys_clk);
        #2;
        check("rst_miso", miso_out, 0);
        check("rst_xfer_active", xfer_active, 0);
        check("rst_resp_full", resp_full, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_frame_end", cmd_frame_end, 0);
        check("rst_resp_level", resp_level, 0);
        check("rst_err_underflow", err_underflow, 0);
        rst = 1'b0;
        repeat (2) @(posedge sys_clk);

        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin
                for (int k = 0; k < 20; k++) push(rd_w[k/4][31-8*(k%4) -: 8]);
                check("preload_level", resp_level, 20);
            end
            c0 = n_cmd;
            f0 = n_fe;
            spi_frame(vt[i].hdr, vt[i].n, vt[i].tx, rxh, rx);
            check($sformatf("v%0d_hdr_miso", i), rxh, 32'h0);
            if (vt[i].chk_rx) check($sformatf("v%0d_miso_data", i), rx, vt[i].exp_rx);
            check($sformatf("v%0d_cmd_count", i), n_cmd - c0, vt[i].exp_cmd);
            if (vt[i].exp_cmd == 1) begin
                cb = (cmd_q.size() > 0) ? {24'h0, cmd_q.pop_front()} : 32'hFFFFFFFF;
                check($sformatf("v%0d_cmd_data", i), cb, {24'h0, vt[i].tx[31:24]});
            end
            check($sformatf("v%0d_frame_end_count", i), n_fe - f0, vt[i].exp_fe);
            if (i == 16) begin
                check("reads_level_end", resp_level, 0);
                check("reads_no_underflow", err_underflow, 0);
            end
            if (i == 17) check("underflow_set", err_underflow, 1);
            if (i == 19) check("underflow_sticky", err_underflow, 1);
        end

        // Aborted write: SS drops after 5 bits of the data byte.
        c0 = n_cmd;
        @(posedge sys_clk);
        #2;
        ss_in = 1'b0;
        #80;
        for (int k = 0; k < 4; k++) begin
            v = 8'(32'h00D40024 >> (24 - 8*k));
            spi_byte(v, 8, b);
        end
        spi_byte(8'hA5, 5, b);
        #80;
        ss_in = 1'b1;
        t_ss_off = $time;
        #400;
        check("abort_no_cmd", n_cmd - c0, 0);
        check("abort_xfer_idle", xfer_active, 0);
        spi_frame(32'h00D40024, 1, 32'h5A000000, rxh, rx);
        check("after_abort_cmd_count", n_cmd - c0, 1);
        cb = (cmd_q.size() > 0) ? {24'h0, cmd_q.pop_front()} : 32'hFFFFFFFF;
        check("after_abort_cmd_data", cb, 32'h5A);

        // Reset clears the sticky underflow flag.
        @(posedge sys_clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        rst = 1'b0;
        check("rst2_err_cleared", err_underflow, 0);
        check("rst2_level", resp_level, 0);

        // Status register reads.
        spi_frame(32'h81D40018, 2, 32'h0, rxh, rx);
        check("sts_empty", rx, {EXP_STS_EMPTY, EXP_STS_EMPTY, 16'h0});
        push(8'h77);
        check("push_level_next_cycle", resp_level, 1);
        spi_frame(32'h80D40018, 1, 32'h0, rxh, rx);
        check("sts_avail", rx, {EXP_STS_AVAIL, 24'h0});
        spi_frame(32'h80D40024, 1, 32'h0, rxh, rx);
        check("fifo_after_sts", rx, 32'h77000000);
        check("fifo_after_sts_level", resp_level, 0);

        // Fill past capacity, then drain across the pointer wrap.
        for (int i = 0; i < 33; i++) begin
            v = 8'(8'h10 + i);
            push(v);
            if (mq.size() < 32) mq.push_back(v);
        end
        check("full_level", resp_level, 32);
        check("full_flag", resp_full, 1);
        read4_model("wrap_read_first");
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h40 + i);
            push(v);
            mq.push_back(v);
        end
        check("refill_full", resp_full, 1);
        for (int i = 0; i < 8; i++) read4_model($sformatf("wrap_read_%0d", i));
        check("drain_level", resp_level, 0);
        check("drain_full", resp_full, 0);
        check("drain_no_underflow", err_underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
